// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiply-accumulate back end.
package booth_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 20;
  localparam int LEN_W_DEF  = 8;

  // Clamp limits of a default-width accumulator.
  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed saturating adder. The sum is formed one bit wider
// than the operands. When the top two bits of that sum disagree the true
// result does not fit, and the output clamps toward the sign of the true sum.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] addend,
  output logic [W-1:0] sum,
  output logic         overflow
);

  logic [W:0]   wide;
  logic [W-1:0] max_val;
  logic [W-1:0] min_val;

  assign max_val = {1'b0, {(W-1){1'b1}}};
  assign min_val = {1'b1, {(W-1){1'b0}}};
  assign wide    = {acc[W-1], acc} + {addend[W-1], addend};

  // Clamp to the rail selected by the sign of the wide sum.
  always_comb begin
    overflow = (wide[W] != wide[W-1]);
    sum      = wide[W-1:0];
    if (overflow) begin
      sum = wide[W] ? min_val : max_val;
    end
  end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Accumulates a programmed number of signed products into a saturating
// accumulator and hands the result downstream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. prod_ready and acc_valid depend only on the registered state,
// so no input reaches an output combinationally. A producer may hold
// prod_valid low for any number of cycles. acc_out and sat_flag stay stable
// while acc_valid is high and acc_ready is low.
module booth_mac_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              sat_flag,
  output logic [1:0]        dbg_state
);

  mac_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic             sat;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             overflow;

  assign prod_ext = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};

  booth_sat_add #(.W(ACC_W)) u_sat_add (
    .acc      (acc),
    .addend   (prod_ext),
    .sum      (sum),
    .overflow (overflow)
  );

  // Run control: load on start, add one product per beat, hold the result until it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            sat   <= 1'b0;
            count <= len;
            // A zero-length run has nothing to add and goes straight to DONE.
            state <= (len != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc   <= sum;
            count <= count - 1'b1;
            if (overflow) begin
              sat <= 1'b1;
            end
            if (count == LEN_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc;
  assign sat_flag   = sat;
  assign dbg_state  = state;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Bench for booth_mac_accumulator. A reference model sums the product list
// with plain integer arithmetic and clamps the running total to the 20-bit
// signed range.
module tb_booth_mac_accumulator;

  localparam longint MAXV = 524287;
  localparam longint MINV = -524288;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [15:0] prod_in = '0;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [19:0] acc_out;
  logic        acc_valid;
  logic        acc_ready = 1'b0;
  logic        busy;
  logic        sat_flag;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [15:0] prods[$];
  logic [19:0]        exp_q[$];
  bit                 exp_sat;
  int                 exp_sat_beat;

  booth_mac_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .busy       (busy),
    .sat_flag   (sat_flag),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: saturating sum of the product list.
  task automatic model_run(input int n);
    longint s;
    s = 0;
    exp_sat = 1'b0;
    exp_sat_beat = 0;
    for (int i = 0; i < n; i++) begin
      s = s + longint'(prods[i]);
      if (s > MAXV || s < MINV) begin
        s = (s > MAXV) ? MAXV : MINV;
        exp_sat = 1'b1;
        if (exp_sat_beat == 0) exp_sat_beat = i + 1;
      end
    end
    exp_q.push_back(s[19:0]);
  endtask

  // Driver: start a run of n beats, with gap idle cycles before each beat.
  task automatic run_products(input int n, input int gap, input bit rand_gap,
                              output int cycles, output bit rdy_ok, output int sat_beat);
    int guard;
    int k;
    rdy_ok = 1'b1;
    sat_beat = 0;
    start = 1'b1;
    len = 8'(n);
    tick();
    start = 1'b0;
    cycles = 1;
    for (int i = 0; i < n; i++) begin
      k = rand_gap ? int'($urandom_range(0, 3)) : gap;
      repeat (k) begin
        prod_valid = 1'b0;
        prod_in = 16'($urandom);
        if (prod_ready !== 1'b1) rdy_ok = 1'b0;
        tick();
        cycles++;
      end
      prod_valid = 1'b1;
      prod_in = prods[i];
      if (prod_ready !== 1'b1) rdy_ok = 1'b0;
      tick();
      cycles++;
      prod_valid = 1'b0;
      if (sat_flag === 1'b1 && sat_beat == 0) sat_beat = i + 1;
    end
    guard = 0;
    while (acc_valid !== 1'b1 && guard < 20) begin
      tick();
      cycles++;
      guard++;
    end
  endtask

  // Take the result, then confirm the block is back in IDLE.
  task automatic accept_and_check(input string name);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    n_cmp++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_handoff: acc_valid=%b busy=%b, required 0 0", name, acc_valid, busy);
    end
  endtask

  // Compare the held result and saturation flag against the model.
  task automatic check_result(input string name);
    logic [19:0] exp;
    exp = exp_q.pop_front();
    n_cmp++;
    if (acc_valid !== 1'b1 || acc_out !== exp) begin
      n_err++;
      $display("FAIL %s_acc: acc_valid=%b acc_out=%h, required 1 %h", name, acc_valid, acc_out, exp);
    end
    n_cmp++;
    if (sat_flag !== exp_sat) begin
      n_err++;
      $display("FAIL %s_sat: sat_flag=%b, required %b", name, sat_flag, exp_sat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({acc_out, acc_valid, prod_ready, busy, sat_flag} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_outputs: acc_out=%h v=%b r=%b busy=%b sat=%b, required all zero",
               acc_out, acc_valid, prod_ready, busy, sat_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sum_of_products();
    int cyc; bit rdy; int sb;
    prods = '{16'sd40, -16'sd1, 16'sd12, 16'sd56};
    model_run(4);
    run_products(4, 0, 1'b0, cyc, rdy, sb);
    n_cmp++;
    if (cyc != 5) begin
      n_err++;
      $display("FAIL sum_latency: acc_valid after %0d cycles, required 5", cyc);
    end
    n_cmp++;
    if (acc_out !== 20'h0006B) begin
      n_err++;
      $display("FAIL sum_value: acc_out=%h, required 0006b", acc_out);
    end
    check_result("sum");
    accept_and_check("sum");
  endtask

  task automatic test_signed_stalls();
    int cyc; bit rdy; int sb;
    prods = '{-16'sd110, 16'sd25, 16'sd30};
    model_run(3);
    run_products(3, 2, 1'b0, cyc, rdy, sb);
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_ready: prod_ready dropped in ACCUM, got %b required 1", rdy);
    end
    n_cmp++;
    if (cyc != 10) begin
      n_err++;
      $display("FAIL stall_latency: acc_valid after %0d cycles, required 10", cyc);
    end
    check_result("stall");
    accept_and_check("stall");
  endtask

  task automatic test_saturation();
    int cyc; bit rdy; int sb;
    for (int pass = 0; pass < 2; pass++) begin
      prods.delete();
      for (int i = 0; i < 40; i++) prods.push_back(pass == 0 ? 16'sd16384 : -16'sd16384);
      model_run(40);
      run_products(40, 0, 1'b0, cyc, rdy, sb);
      n_cmp++;
      if (sb != exp_sat_beat) begin
        n_err++;
        $display("FAIL sat_first_beat: sat_flag first seen at beat %0d, required %0d", sb, exp_sat_beat);
      end
      check_result(pass == 0 ? "sat_pos" : "sat_neg");
      accept_and_check("sat");
    end
  endtask

  task automatic test_zero_len_backpressure();
    int cyc; bit rdy; int sb;
    prods.delete();
    model_run(0);
    run_products(0, 0, 1'b0, cyc, rdy, sb);
    n_cmp++;
    if (cyc != 1) begin
      n_err++;
      $display("FAIL zero_latency: acc_valid after %0d cycles, required 1", cyc);
    end
    check_result("zero");
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len = 8'd7;
      tick();
      n_cmp++;
      if (acc_valid !== 1'b1 || acc_out !== 20'h0 || busy !== 1'b1 || sat_flag !== 1'b0) begin
        n_err++;
        $display("FAIL hold_stable: cycle %0d acc_valid=%b acc_out=%h busy=%b sat=%b, required 1 00000 1 0",
                 i, acc_valid, acc_out, busy, sat_flag);
      end
    end
    start = 1'b0;
    accept_and_check("zero");
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit rdy; int sb;
    start = 1'b1;
    len = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1;
      prod_in = 16'd1000;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({acc_out, acc_valid, prod_ready, busy, sat_flag} !== 24'h0) begin
      n_err++;
      $display("FAIL midrun_reset: acc_out=%h v=%b r=%b busy=%b sat=%b, required all zero",
               acc_out, acc_valid, prod_ready, busy, sat_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (acc_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midrun_no_result: acc_valid=%b busy=%b, required 0 0", acc_valid, busy);
      end
    end
    prod_valid = 1'b0;
    prods = '{16'sd25};
    model_run(1);
    run_products(1, 0, 1'b0, cyc, rdy, sb);
    check_result("after_reset");
    accept_and_check("after_reset");
  endtask

  task automatic test_back_to_back();
    int cyc; bit rdy; int sb;
    int n;
    for (int r = 0; r < 3; r++) begin
      prods.delete();
      n = (r == 2) ? 255 : int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) prods.push_back(16'($urandom));
      model_run(n);
      acc_ready = 1'b1;
      run_products(n, 0, 1'b0, cyc, rdy, sb);
      check_result("b2b");
      tick();
      acc_ready = 1'b0;
      n_cmp++;
      if (acc_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_single_done: acc_valid=%b busy=%b, required 0 0", acc_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    int cyc; bit rdy; int sb;
    int n;
    for (int r = 0; r < 25; r++) begin
      prods.delete();
      n = int'($urandom_range(0, 12));
      if (r % 5 == 4) n = 40;
      for (int i = 0; i < n; i++) prods.push_back(16'($urandom));
      model_run(n);
      run_products(n, 0, 1'b1, cyc, rdy, sb);
      n_cmp++;
      if (rdy !== 1'b1) begin
        n_err++;
        $display("FAIL rand_ready: run %0d prod_ready dropped, got %b required 1", r, rdy);
      end
      n_cmp++;
      if (sb != exp_sat_beat) begin
        n_err++;
        $display("FAIL rand_sat_beat: run %0d got %0d required %0d", r, sb, exp_sat_beat);
      end
      check_result("rand");
      repeat (int'($urandom_range(0, 2))) tick();
      accept_and_check("rand");
    end
  endtask

  initial begin
    test_reset();
    test_sum_of_products();
    test_signed_stalls();
    test_saturation();
    test_zero_len_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mac_accumulator.md
# booth_mac_accumulator

Multiply-accumulate back end for the 8-bit Booth multiplier. It consumes the multiplier's 16-bit signed `Product` stream and accumulates a programmed number of products into a saturating signed accumulator. It presents the sum downstream with a valid/ready handshake. It sits directly after `Booths_Multiplier_8bit`, which drives `prod_in`, and turns the multiplier into a dot-product engine.

## Interface
- `PROD_W`, default 16: product width, two's complement; matches the multiplier `Product`.
- `ACC_W`, default 20: accumulator width, two's complement; must be > `PROD_W`.
- `LEN_W`, default 8: width of the beat-count field.
- `clk`, in, 1: the one clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: begins an accumulation; sampled only in IDLE.
- `len`, in, `LEN_W`: number of products to accumulate; sampled with `start`.
- `prod_in`, in, `PROD_W`: signed product from the multiplier.
- `prod_valid`, in, 1: `prod_in` holds a product to consume.
- `prod_ready`, out, 1: block accepts a product this cycle.
- `acc_out`, out, `ACC_W`: signed accumulated result.
- `acc_valid`, out, 1: `acc_out` is final.
- `acc_ready`, in, 1: downstream takes the result.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `sat_flag`, out, 1: sticky; high if any add in the current run saturated.

## Operation
- FSM has three states: IDLE, ACCUM, DONE.
- **IDLE**
  - `start`=1 and `len`≠0: clear acc to 0, clear `sat_flag`, load count=`len`, go to ACCUM.
  - `start`=1 and `len`=0: clear acc to 0, clear `sat_flag`, go directly to DONE, so result = 0.
- **ACCUM**
  - `prod_ready`=1.
  - A beat is the cycle where `prod_valid & prod_ready` is high. On each beat:
    - acc ← sat(acc + sign-extended `prod_in`);
    - count ← count−1.
  - On the beat where count=1, go to DONE.
  - Cycles without `prod_valid` change nothing; stalls of any length are allowed.
- **DONE**
  - `acc_valid`=1; `acc_out` and `sat_flag` are held stable.
  - On `acc_valid & acc_ready`, go to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- **Saturation:** compute the sum at `ACC_W`+1 bits.
  - Sum > 2^(ACC_W−1)−1: clamp to the maximum and set `sat_flag`.
  - Sum < −2^(ACC_W−1): clamp to the minimum and set `sat_flag`.
  - Later beats continue from the clamped value.
- `acc_out` always shows the live accumulator. It is meaningful only while `acc_valid`=1.

## Timing
- **Reset values:**
  - state = IDLE; acc = 0; count = 0;
  - `acc_out`=0, `acc_valid`=0, `prod_ready`=0, `busy`=0, `sat_flag`=0.
- Reset mid-run aborts the run immediately, asynchronously. No partial result is emitted.
- `prod_ready`, `acc_valid` and `busy` are decoded from the registered state only. They have no combinational path from inputs.
- ACCUM is entered the cycle after `start`. The first beat can happen in that cycle.
- Throughput is one product per cycle.
- `acc_valid` rises the cycle after the last beat. With no stalls, `len`=N gives `acc_valid` N+1 cycles after the `start` edge.
- If `acc_ready` is already high when `acc_valid` rises, DONE lasts exactly 1 cycle.
- The earliest next `start` is accepted the cycle after the DONE→IDLE handoff.
- The count wraps nowhere: `len`=2^LEN_W−1 is the maximum run.

## Structure
- Shared package `booth_pkg` holds:
  - `PROD_W`, `ACC_W` and `LEN_W` defaults;
  - the state enum `mac_state_t` {IDLE, ACCUM, DONE};
  - `ACC_MAX` / `ACC_MIN` localparams derived from `ACC_W`.
- One sub-module, `booth_sat_add`: a combinational signed saturating adder.
  - Inputs: acc, sign-extended product.
  - Outputs: sum, overflow.
- The FSM, the counter and the handshake stay in the top module.

## Test plan
- **Sum of products:** `len`=4, products 40, −1, 12, 56 (4×10, 1×−1, 6×2, 7×8), back-to-back → `acc_out`=107 (0x0006B), `sat_flag`=0, `acc_valid` at cycle 5 after start.
- **Signed mix with stalls:** `len`=3, products −110, 25, 30 with 2-cycle `prod_valid` gaps → `acc_out`=−55 (0xFFFC9); `prod_ready` high throughout ACCUM.
- **Saturation:**
  - `len`=40, `prod_in`=16384 every cycle → `acc_out`=524287 (0x7FFFF), `sat_flag`=1 (first set on beat 32).
  - Repeat with −16384 → 0x80000.
- **Zero length and back-pressure:** `len`=0 → `acc_valid` the cycle after start with `acc_out`=0. Hold `acc_ready`=0 for 5 cycles → output stable; `start` pulses during DONE are ignored.
- **Reset mid-run:** assert `rst` after 2 of 4 beats → all outputs return to reset values immediately, and no `acc_valid` follows. A new run with `len`=1, product 25 then gives 25.
